// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared types and constants for the fetch sequencer.
// Holds the FSM state encoding, the registered bundle layout and the
// default reset PC / instruction stride.
package fetch_sequencer_pkg;

  localparam int FS_ADDR_WIDTH  = 32;
  localparam int FS_DATA_WIDTH  = 32;
  localparam logic [FS_ADDR_WIDTH-1:0] FS_RESET_PC = 32'h0000_0000;
  localparam int FS_INSTR_BYTES = 4;

  // State encoding kept as plain constants so older tools and waveform
  // scripts that expect raw 2-bit codes keep working.
  typedef logic [1:0] fetch_seq_state_t;
  localparam fetch_seq_state_t BOOT  = 2'd0;
  localparam fetch_seq_state_t RUN   = 2'd1;
  localparam fetch_seq_state_t HOLD  = 2'd2;
  localparam fetch_seq_state_t FLUSH = 2'd3;

  typedef struct packed {
    logic [1:0]               valid;
    logic [FS_ADDR_WIDTH-1:0] addr0;
    logic [FS_ADDR_WIDTH-1:0] addr1;
    logic [FS_DATA_WIDTH-1:0] instr0;
    logic [FS_DATA_WIDTH-1:0] instr1;
    logic [1:0]               pred_taken;
    logic [FS_ADDR_WIDTH-1:0] pred_target;
  } fetch_bundle_t;

  // Number of valid slots in a two-wide bundle.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the fetch-stage, redirect and decode-side
// signals of the fetch sequencer. The master modport is the sequencer,
// the slave modport is its surroundings (fetch stage, backend, decode).
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = FS_ADDR_WIDTH,
  parameter int DATA_WIDTH = FS_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] instruction_addr_0;
  logic [ADDR_WIDTH-1:0] instruction_addr_1;
  logic [DATA_WIDTH-1:0] instruction_0;
  logic [DATA_WIDTH-1:0] instruction_1;
  logic [1:0]            instruction_valid;
  logic                  predict_taken_0;
  logic [ADDR_WIDTH-1:0] predict_target_0;
  logic                  predict_taken_1;
  logic [ADDR_WIDTH-1:0] predict_target_1;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  fetch_ready;
  logic [1:0]            fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr_0;
  logic [ADDR_WIDTH-1:0] fetch_addr_1;
  logic [DATA_WIDTH-1:0] fetch_instr_0;
  logic [DATA_WIDTH-1:0] fetch_instr_1;
  logic [1:0]            fetch_pred_taken;
  logic [ADDR_WIDTH-1:0] fetch_pred_target;

  modport master (
    output pc, fetch_valid, fetch_addr_0, fetch_addr_1, fetch_instr_0,
           fetch_instr_1, fetch_pred_taken, fetch_pred_target,
    input  instruction_addr_0, instruction_addr_1, instruction_0,
           instruction_1, instruction_valid, predict_taken_0,
           predict_target_0, predict_taken_1, predict_target_1,
           redirect_valid, redirect_pc, fetch_ready
  );

  modport slave (
    input  pc, fetch_valid, fetch_addr_0, fetch_addr_1, fetch_instr_0,
           fetch_instr_1, fetch_pred_taken, fetch_pred_target,
    output instruction_addr_0, instruction_addr_1, instruction_0,
           instruction_1, instruction_valid, predict_taken_0,
           predict_target_0, predict_taken_1, predict_target_1,
           redirect_valid, redirect_pc, fetch_ready
  );

endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// fetch_next_pc: purely combinational next-PC selection for a two-wide
// fetch bundle. The last valid slot decides: its predicted target when
// the BTB says taken, otherwise the address just past it.
module fetch_next_pc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic [1:0]            valid_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic                  taken0_i,
  input  logic                  taken1_i,
  input  logic [ADDR_WIDTH-1:0] target0_i,
  input  logic [ADDR_WIDTH-1:0] target1_i,
  output logic [ADDR_WIDTH-1:0] nextPc_o
);

  // Pick the continuation of the last valid slot; sums wrap silently.
  always_comb begin
    nextPc_o = taken0_i ? target0_i : addr0_i + ADDR_WIDTH'(INSTR_BYTES);
    case (valid_i)
      2'b11:   nextPc_o = taken1_i ? target1_i : addr1_i + ADDR_WIDTH'(INSTR_BYTES);
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, registers each fetched bundle into a
// single output slot toward decode, stalls under decode backpressure and
// applies backend redirects.
// Optional build macro FETCH_SEQ_PERF_CNT_EN adds three 32-bit performance
// counters (instructions consumed, HOLD cycles, redirects).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = FS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = FS_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = FS_RESET_PC,
  parameter int                    INSTR_BYTES = FS_INSTR_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
`ifdef FETCH_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_instr_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_redirect_cnt
`endif
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, nextPc;
  fetch_seq_state_t      state_q, state_d;
  fetch_bundle_t         bundle_q, bundle_d, bundleIn;
  logic                  consume, loadOk;

  // The slot is drained when decode takes it, and may be refilled when it
  // is empty or being drained in this same cycle.
  assign consume = (bundle_q.valid != 2'b00) && bus.fetch_ready;
  assign loadOk  = (bundle_q.valid == 2'b00) || bus.fetch_ready;

  fetch_next_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_next_pc (
    .valid_i  (bus.instruction_valid),
    .addr0_i  (bus.instruction_addr_0),
    .addr1_i  (bus.instruction_addr_1),
    .taken0_i (bus.predict_taken_0),
    .taken1_i (bus.predict_taken_1),
    .target0_i(bus.predict_target_0),
    .target1_i(bus.predict_target_1),
    .nextPc_o (nextPc)
  );

  // Pack the incoming fetch-stage bundle; predictions of invalid slots are
  // masked and the target kept is the one of the last valid slot.
  always_comb begin
    bundleIn             = '0;
    bundleIn.valid       = bus.instruction_valid;
    bundleIn.addr0       = FS_ADDR_WIDTH'(bus.instruction_addr_0);
    bundleIn.addr1       = FS_ADDR_WIDTH'(bus.instruction_addr_1);
    bundleIn.instr0      = FS_DATA_WIDTH'(bus.instruction_0);
    bundleIn.instr1      = FS_DATA_WIDTH'(bus.instruction_1);
    bundleIn.pred_taken  = {bus.predict_taken_1 & bus.instruction_valid[1],
                            bus.predict_taken_0 & bus.instruction_valid[0]};
    bundleIn.pred_target = bus.instruction_valid[1] ? FS_ADDR_WIDTH'(bus.predict_target_1)
                                                    : FS_ADDR_WIDTH'(bus.predict_target_0);
  end

  // Next-state logic: redirect wins over everything, BOOT/FLUSH are single
  // bubble cycles, RUN/HOLD stream bundles whenever the slot can take one.
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    bundle_d = bundle_q;
    if (bus.redirect_valid) begin
      pc_d           = bus.redirect_pc;
      bundle_d.valid = 2'b00;
      state_d        = FLUSH;
    end else begin
      case (state_q)
        BOOT, FLUSH: state_d = RUN;
        default: begin
          if (loadOk) begin
            state_d = RUN;
            if (bus.instruction_valid != 2'b00) begin
              bundle_d = bundleIn;
              pc_d     = nextPc;
            end else if (consume) begin
              bundle_d.valid = 2'b00;
            end
          end else begin
            state_d = HOLD;
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset back to the boot PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= BOOT;
      bundle_q <= '0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.pc                = pc_q;
  assign bus.fetch_valid       = bundle_q.valid;
  assign bus.fetch_addr_0      = ADDR_WIDTH'(bundle_q.addr0);
  assign bus.fetch_addr_1      = ADDR_WIDTH'(bundle_q.addr1);
  assign bus.fetch_instr_0     = DATA_WIDTH'(bundle_q.instr0);
  assign bus.fetch_instr_1     = DATA_WIDTH'(bundle_q.instr1);
  assign bus.fetch_pred_taken  = bundle_q.pred_taken;
  assign bus.fetch_pred_target = ADDR_WIDTH'(bundle_q.pred_target);

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [31:0] perfInstr_q, perfStall_q, perfRedirect_q;

  // Free-running wrap-around counters; a bundle dropped by a redirect is
  // not counted as consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfInstr_q    <= '0;
      perfStall_q    <= '0;
      perfRedirect_q <= '0;
    end else begin
      if (consume && !bus.redirect_valid)
        perfInstr_q <= perfInstr_q + 32'(popcount2(bundle_q.valid));
      if (state_q == HOLD)
        perfStall_q <= perfStall_q + 32'd1;
      if (bus.redirect_valid)
        perfRedirect_q <= perfRedirect_q + 32'd1;
    end
  end

  assign perf_instr_cnt    = perfInstr_q;
  assign perf_stall_cnt    = perfStall_q;
  assign perf_redirect_cnt = perfRedirect_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario-driven bench for fetch_sequencer. A small
// fetch-stage model answers the DUT pc; every bundle expected to be
// captured is queued and checked when decode consumes it.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Fetch-stage model knobs.
  logic [1:0]  ivalid = 2'b11;
  logic        btb0En = 1'b0;
  logic [31:0] btb0Pc = '0;
  logic [31:0] btb0Target = '0;
  logic        btb1En = 1'b0;
  logic [31:0] btb1Pc = '0;
  logic [31:0] btb1Target = '0;

  fetch_bundle_t sbQ[$];

  fetch_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [31:0] perfInstr, perfStall, perfRedirect;
  fetch_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_instr_cnt(perfInstr), .perf_stall_cnt(perfStall), .perf_redirect_cnt(perfRedirect)
  );
`else
  fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  // Combinational fetch stage: two sequential words at pc plus BTB lookups.
  assign bus.instruction_addr_0 = bus.pc;
  assign bus.instruction_addr_1 = bus.pc + 32'd4;
  assign bus.instruction_0      = instrOf(bus.pc);
  assign bus.instruction_1      = instrOf(bus.pc + 32'd4);
  assign bus.instruction_valid  = ivalid;
  assign bus.predict_taken_0    = btb0En && (bus.pc == btb0Pc);
  assign bus.predict_target_0   = bus.predict_taken_0 ? btb0Target : bus.pc + 32'h200;
  assign bus.predict_taken_1    = btb1En && (bus.pc == btb1Pc);
  assign bus.predict_target_1   = bus.predict_taken_1 ? btb1Target : bus.pc + 32'h300;

  // Expected registered bundle for a fetch at address p with validity v.
  function automatic fetch_bundle_t expBundle(input logic [31:0] p, input logic [1:0] v);
    fetch_bundle_t b;
    logic hit0, hit1;
    hit0 = btb0En && (p == btb0Pc);
    hit1 = btb1En && (p == btb1Pc);
    b.valid       = v;
    b.addr0       = p;
    b.addr1       = p + 32'd4;
    b.instr0      = instrOf(p);
    b.instr1      = instrOf(p + 32'd4);
    b.pred_taken  = {v[1] & hit1, v[0] & hit0};
    b.pred_target = v[1] ? (hit1 ? btb1Target : p + 32'h300) : (hit0 ? btb0Target : p + 32'h200);
    return b;
  endfunction

  // Scoreboard: a full slot leaves on consume (checked), reset or redirect
  // (dropped); any bundle with nothing queued is unexpected.
  always @(negedge clk) begin
    fetch_bundle_t exp, act;
    if (bus.fetch_valid != 2'b00 && (rst || bus.redirect_valid || bus.fetch_ready)) begin
      if (sbQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_bundle got valid %b addr0 %h, required none", bus.fetch_valid, bus.fetch_addr_0);
      end else begin
        exp = sbQ.pop_front();
        if (!rst && !bus.redirect_valid) begin
          act = '{valid: bus.fetch_valid, addr0: bus.fetch_addr_0, addr1: bus.fetch_addr_1,
                  instr0: bus.fetch_instr_0, instr1: bus.fetch_instr_1,
                  pred_taken: bus.fetch_pred_taken, pred_target: bus.fetch_pred_target};
          checks++;
          if (act !== exp) begin
            errors++;
            $display("[TB] FAIL bundle got %h required %h", act, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.fetch_ready = 1'b1;
    ivalid = 2'b11;
    btb0En = 1'b0;
    btb1En = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h1234;
    bus.fetch_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h required %h", bus.pc, 32'h0); end
    checks++; if (bus.fetch_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid got %b required 00", bus.fetch_valid); end
    checks++; if ({bus.fetch_addr_0, bus.fetch_addr_1, bus.fetch_instr_0, bus.fetch_instr_1} !== 128'h0) begin errors++; $display("[TB] FAIL reset_data got %h %h %h %h required 0", bus.fetch_addr_0, bus.fetch_addr_1, bus.fetch_instr_0, bus.fetch_instr_1); end
    checks++; if ({bus.fetch_pred_taken, bus.fetch_pred_target} !== 34'h0) begin errors++; $display("[TB] FAIL reset_pred got %b %h required 0", bus.fetch_pred_taken, bus.fetch_pred_target); end
    checks++; if (dut.state_q !== BOOT) begin errors++; $display("[TB] FAIL reset_state got %0d required %0d", dut.state_q, BOOT); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    doReset();
    tick();
    checks++; if (dut.state_q !== RUN || bus.pc !== 32'h0) begin errors++; $display("[TB] FAIL stream_boot got state %0d pc %h required %0d 0", dut.state_q, bus.pc, RUN); end
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h8) begin errors++; $display("[TB] FAIL stream_pc1 got %h required 8", bus.pc); end
    checks++; if (bus.fetch_addr_0 !== 32'h0 || bus.fetch_addr_1 !== 32'h4 || bus.fetch_valid !== 2'b11) begin errors++; $display("[TB] FAIL stream_slot got %h %h %b required 0 4 11", bus.fetch_addr_0, bus.fetch_addr_1, bus.fetch_valid); end
    sbQ.push_back(expBundle(32'h8, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("[TB] FAIL stream_pc2 got %h required 10", bus.pc); end
    sbQ.push_back(expBundle(32'h10, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h18) begin errors++; $display("[TB] FAIL stream_pc3 got %h required 18", bus.pc); end
  endtask

  task automatic test_predict();
    doReset();
    btb1En = 1'b1; btb1Pc = 32'h8; btb1Target = 32'h100;
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    sbQ.push_back(expBundle(32'h8, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("[TB] FAIL predict_pc got %h required 100", bus.pc); end
    checks++; if (bus.fetch_pred_taken !== 2'b10 || bus.fetch_pred_target !== 32'h100) begin errors++; $display("[TB] FAIL predict_slot got %b %h required 10 100", bus.fetch_pred_taken, bus.fetch_pred_target); end
    sbQ.push_back(expBundle(32'h100, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h108 || bus.fetch_pred_taken !== 2'b00) begin errors++; $display("[TB] FAIL predict_after got %h %b required 108 00", bus.pc, bus.fetch_pred_taken); end
  endtask

  task automatic test_single_slot();
    doReset();
    ivalid = 2'b01;
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b01));
    tick();
    checks++; if (bus.pc !== 32'h4 || bus.fetch_valid !== 2'b01 || bus.fetch_pred_target !== 32'h200) begin errors++; $display("[TB] FAIL single_slot got %h %b %h required 4 01 200", bus.pc, bus.fetch_valid, bus.fetch_pred_target); end
    ivalid = 2'b00;
    tick();
    checks++; if (bus.fetch_valid !== 2'b00 || bus.pc !== 32'h4) begin errors++; $display("[TB] FAIL empty_fetch got %b %h required 00 4", bus.fetch_valid, bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'h4 || dut.state_q !== RUN) begin errors++; $display("[TB] FAIL empty_retry got %h %0d required 4 %0d", bus.pc, dut.state_q, RUN); end
    btb0En = 1'b1; btb0Pc = 32'h4; btb0Target = 32'h600;
    ivalid = 2'b01;
    sbQ.push_back(expBundle(32'h4, 2'b01));
    tick();
    checks++; if (bus.pc !== 32'h600 || bus.fetch_pred_taken !== 2'b01 || bus.fetch_pred_target !== 32'h600) begin errors++; $display("[TB] FAIL slot0_taken got %h %b %h required 600 01 600", bus.pc, bus.fetch_pred_taken, bus.fetch_pred_target); end
  endtask

  task automatic test_hold();
    doReset();
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== 32'h8 || bus.fetch_addr_0 !== 32'h0 || bus.fetch_instr_1 !== instrOf(32'h4) || dut.state_q !== HOLD) begin errors++; $display("[TB] FAIL hold_%0d got pc %h addr0 %h instr1 %h state %0d required 8 0 %h %0d", i, bus.pc, bus.fetch_addr_0, bus.fetch_instr_1, dut.state_q, instrOf(32'h4), HOLD); end
    end
    bus.fetch_ready = 1'b1;
    sbQ.push_back(expBundle(32'h8, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h10 || bus.fetch_addr_0 !== 32'h8 || dut.state_q !== RUN) begin errors++; $display("[TB] FAIL hold_release got %h %h %0d required 10 8 %0d", bus.pc, bus.fetch_addr_0, dut.state_q, RUN); end
  endtask

  task automatic test_redirect();
    doReset();
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    bus.fetch_ready = 1'b0;
    tick();
    checks++; if (dut.state_q !== HOLD) begin errors++; $display("[TB] FAIL redir_hold got %0d required %0d", dut.state_q, HOLD); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    checks++; if (bus.fetch_valid !== 2'b00 || bus.pc !== 32'h200 || dut.state_q !== FLUSH) begin errors++; $display("[TB] FAIL redir_apply got %b %h %0d required 00 200 %0d", bus.fetch_valid, bus.pc, dut.state_q, FLUSH); end
    bus.redirect_valid = 1'b0;
    tick();
    checks++; if (bus.fetch_valid !== 2'b00 || bus.pc !== 32'h200 || dut.state_q !== RUN) begin errors++; $display("[TB] FAIL redir_bubble got %b %h %0d required 00 200 %0d", bus.fetch_valid, bus.pc, dut.state_q, RUN); end
    bus.fetch_ready = 1'b1;
    sbQ.push_back(expBundle(32'h200, 2'b11));
    tick();
    checks++; if (bus.fetch_addr_0 !== 32'h200 || bus.pc !== 32'h208) begin errors++; $display("[TB] FAIL redir_refill got %h %h required 200 208", bus.fetch_addr_0, bus.pc); end
  endtask

  task automatic test_reset_priority();
    doReset();
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    rst = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 2'b00 || dut.state_q !== BOOT) begin errors++; $display("[TB] FAIL rst_over_redirect got %h %b %0d required 0 00 %0d", bus.pc, bus.fetch_valid, dut.state_q, BOOT); end
    rst = 1'b0; bus.redirect_valid = 1'b0;
  endtask

  task automatic test_back_to_back_redirect();
    doReset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400;
    tick();
    checks++; if (bus.pc !== 32'h400 || dut.state_q !== FLUSH) begin errors++; $display("[TB] FAIL redir1 got %h %0d required 400 %0d", bus.pc, dut.state_q, FLUSH); end
    bus.redirect_pc = 32'h500;
    tick();
    checks++; if (bus.pc !== 32'h500 || dut.state_q !== FLUSH) begin errors++; $display("[TB] FAIL redir2 got %h %0d required 500 %0d", bus.pc, dut.state_q, FLUSH); end
    bus.redirect_valid = 1'b0;
    tick();
    sbQ.push_back(expBundle(32'h500, 2'b11));
    tick();
    checks++; if (bus.fetch_addr_0 !== 32'h500 || bus.pc !== 32'h508) begin errors++; $display("[TB] FAIL redir2_refill got %h %h required 500 508", bus.fetch_addr_0, bus.pc); end
  endtask

  task automatic test_wrap();
    doReset();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    sbQ.push_back(expBundle(32'hFFFF_FFF8, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.fetch_addr_1 !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap got %h %h required 0 fffffffc", bus.pc, bus.fetch_addr_1); end
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    checks++; if (bus.pc !== 32'h8 || bus.fetch_addr_0 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next got %h %h required 8 0", bus.pc, bus.fetch_addr_0); end
    ivalid = 2'b00;
    tick();
    checks++; if (sbQ.size() != 0 || bus.fetch_valid !== 2'b00) begin errors++; $display("[TB] FAIL drain got queue %0d valid %b required 0 00", sbQ.size(), bus.fetch_valid); end
  endtask

`ifdef FETCH_SEQ_PERF_CNT_EN
  task automatic test_perf_counters();
    doReset();
    checks++; if ({perfInstr, perfStall, perfRedirect} !== 96'h0) begin errors++; $display("[TB] FAIL perf_reset got %0d %0d %0d required 0 0 0", perfInstr, perfStall, perfRedirect); end
    tick();
    sbQ.push_back(expBundle(32'h0, 2'b11));
    tick();
    sbQ.push_back(expBundle(32'h8, 2'b11));
    tick();
    sbQ.push_back(expBundle(32'h10, 2'b11));
    tick();
    bus.fetch_ready = 1'b0;
    tick();
    tick();
    bus.fetch_ready = 1'b1;
    sbQ.push_back(expBundle(32'h18, 2'b11));
    tick();
    ivalid = 2'b00;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (perfInstr !== 32'd8 || perfStall !== 32'd2 || perfRedirect !== 32'd1) begin errors++; $display("[TB] FAIL perf_counts got %0d %0d %0d required 8 2 1", perfInstr, perfStall, perfRedirect); end
  endtask
`endif

  // Watchdog so the run always ends even if the clock stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout required summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.fetch_ready = 1'b1;
    test_reset();
    test_stream();
    test_predict();
    test_single_slot();
    test_hold();
    test_redirect();
    test_reset_priority();
    test_back_to_back_redirect();
    test_wrap();
`ifdef FETCH_SEQ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the architectural fetch PC and drives the `pc` input of the two-wide instruction fetch stage.
- Each cycle it captures the fetched bundle (up to 2 instructions plus BTB predictions) into a registered output slot toward decode.
- It computes the next PC from the bundle's validity and predictions.
- It freezes under decode backpressure and applies redirects from the backend (mispredict/exception).
- Sits between InstructionFetch and the decode/instruction queue.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INSTR_BYTES, 4, byte stride between sequential instructions.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc  out  ADDR_WIDTH  current fetch PC to the fetch stage.
- instruction_addr_0  in  ADDR_WIDTH  slot 0 address from the fetch stage.
- instruction_addr_1  in  ADDR_WIDTH  slot 1 address from the fetch stage.
- instruction_0  in  DATA_WIDTH  slot 0 instruction word.
- instruction_1  in  DATA_WIDTH  slot 1 instruction word.
- instruction_valid  in  2  per-slot valid, bit0 = slot 0; legal values 00/01/11.
- predict_taken_0  in  1  BTB taken prediction, slot 0.
- predict_target_0  in  ADDR_WIDTH  BTB target, slot 0.
- predict_taken_1  in  1  BTB taken prediction, slot 1.
- predict_target_1  in  ADDR_WIDTH  BTB target, slot 1.
- redirect_valid  in  1  backend redirect request.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- fetch_ready  in  1  decode accepts the bundle this cycle.
- fetch_valid  out  2  registered bundle slot valids.
- fetch_addr_0  out  ADDR_WIDTH  registered slot 0 address.
- fetch_addr_1  out  ADDR_WIDTH  registered slot 1 address.
- fetch_instr_0  out  DATA_WIDTH  registered slot 0 instruction.
- fetch_instr_1  out  DATA_WIDTH  registered slot 1 instruction.
- fetch_pred_taken  out  2  registered taken predictions per slot.
- fetch_pred_target  out  ADDR_WIDTH  registered predicted target of the last valid slot.

Behaviour:
- Reset (rst=1 at posedge) values:
  - pc=RESET_PC
  - fetch_valid=00
  - all fetch_* data outputs = 0
  - state=BOOT
- States:
  - BOOT: one cycle, no capture; the ROM/BTB read of RESET_PC settles. Goes to RUN.
  - RUN: normal streaming.
  - HOLD: output slot full and fetch_ready=0.
  - FLUSH: one bubble cycle after a redirect, no capture. Goes to RUN.
- Handshake: the bundle is consumed when fetch_valid!=00 && fetch_ready. The slot may load when it is empty or is being consumed this cycle ("load_ok").
- RUN with load_ok and instruction_valid!=00:
  - capture the bundle into fetch_*.
  - pc <= next_pc.
  - stay in RUN.
- RUN with instruction_valid=00: capture nothing, pc holds (fetch retries). If the slot is consumed, fetch_valid<=00.
- RUN without load_ok: pc holds, go to HOLD.
- HOLD: pc and fetch_* hold. On fetch_ready, behave exactly as RUN with load_ok in the same cycle.
- next_pc:
  - valid=11: predict_taken_1 ? predict_target_1 : instruction_addr_1+INSTR_BYTES.
  - valid=01: predict_taken_0 ? predict_target_0 : instruction_addr_0+INSTR_BYTES.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- fetch_pred_target holds the target of the last valid slot.
- Redirect has highest priority, in any state except reset:
  - pc <= redirect_pc.
  - fetch_valid <= 00, even if fetch_ready=1 that cycle; the bundle is dropped.
  - state <= FLUSH.
- Redirect arriving in FLUSH: pc is reloaded and FLUSH is repeated.
- rst overrides redirect.
- Reset mid-HOLD returns everything to reset values.
- Latency: pc presented at cycle N → bundle on fetch_* at N+1.
- Steady state: one bundle per cycle while fetch_ready=1.

Optional Feature:
- Macro FETCH_SEQ_PERF_CNT_EN.
- When defined, adds 32-bit outputs:
  - perf_instr_cnt: += popcount of fetch_valid on each consumed bundle.
  - perf_stall_cnt: +1 each cycle in HOLD.
  - perf_redirect_cnt: +1 per redirect.
- Counters are zero on reset and wrap at 2^32.
- When undefined, ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- typedef_pkg:
  - fetch_seq_state_t enum {BOOT, RUN, HOLD, FLUSH}.
  - fetch_bundle_t packed struct {valid[1:0], addr0, addr1, instr0, instr1, pred_taken[1:0], pred_target}.
- parameter_pkg: RESET_PC, INSTR_BYTES.
- One combinational sub-module, fetch_next_pc: takes the bundle validity and predictions, returns next_pc.

Test Plan:
- Reset, then fetch_ready=1, valid=11, no taken prediction → pc sequence 0x00, 0x08, 0x10; fetch_addr_0/1 = 0x00/0x04 at cycle 2.
- predict_taken_1=1, target 0x100 at pc 0x08 → next pc=0x100; fetch_pred_taken=10, fetch_pred_target=0x100.
- fetch_ready=0 for 3 cycles with a bundle held → pc frozen, fetch_* stable, state HOLD. On release, the held bundle is consumed and the next bundle loads in the same cycle.
- redirect_valid with redirect_pc=0x200 while in HOLD → fetch_valid=00 next cycle, pc=0x200, one FLUSH bubble, then the bundle at 0x200.
- Simultaneous redirect and rst → reset values win (pc=RESET_PC). Redirect on two consecutive cycles → the second redirect_pc is used.
- With FETCH_SEQ_PERF_CNT_EN: 4 consumed 2-wide bundles + 2 HOLD cycles + 1 redirect → counts 8 / 2 / 1.
